// File: rtl/input_event_arbiter.sv
// input_event_arbiter: debounces N_CH synchronized inputs and drains qualified level changes round-robin
// through a valid/ready port. Define INPUT_EVT_TIMESTAMP_EN to add a free-running timestamp and evt_time.

module input_event_arbiter_ch #(
  parameter int DB_W   = 4,
  parameter int DB_CNT = 8
`ifdef INPUT_EVT_TIMESTAMP_EN
  , parameter int TS_W = 16
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_sync,
  input  logic            i_enable,
  input  logic            i_grant,
  input  logic            i_ovf_clr,
`ifdef INPUT_EVT_TIMESTAMP_EN
  input  logic [TS_W-1:0] i_ts,
  output logic [TS_W-1:0] o_pend_time,
`endif
  output logic            o_pending,
  output logic            o_pend_level,
  output logic            o_overflow
);
  localparam logic [DB_W-1:0] LP_LAST = DB_W'(DB_CNT - 1);

  logic [DB_W-1:0] r_cnt;
  logic            r_stable;
  logic            r_pending;
  logic            r_level;
  logic            r_ovf;
  logic            w_diff;
  logic            w_qual;
  logic            w_ovf_set;

  assign w_diff    = i_sync ^ r_stable;
  assign w_qual    = i_enable & w_diff & (r_cnt == LP_LAST);
  // A grant in the same cycle consumes the old event, so a re-qualification then is not an overflow.
  assign w_ovf_set = w_qual & r_pending & ~i_grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_stable  <= 1'b0;
      r_pending <= 1'b0;
      r_level   <= 1'b0;
    end else if (!i_enable) begin
      r_cnt     <= '0;
      r_stable  <= i_sync;
      r_pending <= 1'b0;
    end else begin
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_qual) begin
        r_cnt    <= '0;
        r_stable <= i_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_qual) begin
        r_pending <= 1'b1;
        r_level   <= i_sync;
      end else if (i_grant) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ovf <= 1'b0;
    else        r_ovf <= w_ovf_set | (r_ovf & ~i_ovf_clr);
  end

`ifdef INPUT_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] r_time;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_time <= '0;
    else if (w_qual) r_time <= i_ts;
  end
  assign o_pend_time = r_time;
`endif

  assign o_pending    = r_pending;
  assign o_pend_level = r_level;
  assign o_overflow   = r_ovf;
endmodule

module input_event_arbiter #(
  parameter  int N_CH   = 4,
  parameter  int DB_W   = 4,
  parameter  int DB_CNT = 8,
  parameter  int TS_W   = 16,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] sync_in,
  input  logic [N_CH-1:0] ch_enable,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_level,
`ifdef INPUT_EVT_TIMESTAMP_EN
  output logic [TS_W-1:0] evt_time,
`endif
  output logic [N_CH-1:0] overflow,
  input  logic [N_CH-1:0] ovf_clr
);
  localparam logic [CH_W-1:0] LP_LAST_CH = CH_W'(N_CH - 1);

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            level;
`ifdef INPUT_EVT_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
`endif
  } evt_t;

  if (N_CH < 2 || N_CH > 16 || DB_CNT < 1 || DB_CNT > (1 << DB_W) - 1 || TS_W < 1) begin : g_bad_param
    $error("input_event_arbiter: parameter out of range");
  end

  logic [N_CH-1:0] w_pending;
  logic [N_CH-1:0] w_pend_level;
  logic [N_CH-1:0] w_grant;
  logic [N_CH-1:0] w_overflow;
  logic [CH_W-1:0] r_rr;
  logic [CH_W-1:0] w_win;
  logic [CH_W-1:0] w_idx;
  logic            w_found;
  logic            w_load;
  logic            r_valid;
  evt_t            r_evt;

`ifdef INPUT_EVT_TIMESTAMP_EN
  logic [N_CH-1:0][TS_W-1:0] w_pend_time;
  logic [TS_W-1:0]           r_ts;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ts <= '0;
    else        r_ts <= r_ts + 1'b1;
  end
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    input_event_arbiter_ch #(
      .DB_W   (DB_W),
      .DB_CNT (DB_CNT)
`ifdef INPUT_EVT_TIMESTAMP_EN
      , .TS_W (TS_W)
`endif
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .i_sync       (sync_in[g]),
      .i_enable     (ch_enable[g]),
      .i_grant      (w_grant[g]),
      .i_ovf_clr    (ovf_clr[g]),
`ifdef INPUT_EVT_TIMESTAMP_EN
      .i_ts         (r_ts),
      .o_pend_time  (w_pend_time[g]),
`endif
      .o_pending    (w_pending[g]),
      .o_pend_level (w_pend_level[g]),
      .o_overflow   (w_overflow[g])
    );
  end

  // First pending channel at or above r_rr, wrapping at N_CH.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = r_rr;
    for (int k = 0; k < N_CH; k++) begin
      if (!w_found && w_pending[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
      w_idx = (w_idx == LP_LAST_CH) ? '0 : w_idx + 1'b1;
    end
  end

  assign w_load = ~r_valid | evt_ready;

  always_comb begin
    w_grant = '0;
    if (w_load && w_found) w_grant[w_win] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_evt   <= '0;
      r_rr    <= '0;
    end else if (w_load) begin
      r_valid <= w_found;
      if (w_found) begin
        r_evt.ch    <= w_win;
        r_evt.level <= w_pend_level[w_win];
`ifdef INPUT_EVT_TIMESTAMP_EN
        r_evt.ts    <= w_pend_time[w_win];
`endif
        r_rr        <= (w_win == LP_LAST_CH) ? '0 : w_win + 1'b1;
      end
    end
  end

  assign evt_valid = r_valid;
  assign evt_ch    = r_evt.ch;
  assign evt_level = r_evt.level;
`ifdef INPUT_EVT_TIMESTAMP_EN
  assign evt_time  = r_evt.ts;
`endif
  assign overflow  = w_overflow;
endmodule

// File: tb/tb_input_event_arbiter.sv
// Scoreboard bench for input_event_arbiter: a behavioural model predicts the event stream and overflow
// flags; a negedge monitor pops expected events on every handshake.

module tb_input_event_arbiter;
  localparam int N_CH   = 4;
  localparam int DB_W   = 4;
  localparam int DB_CNT = 8;
  localparam int TS_W   = 16;
  localparam int CH_W   = $clog2(N_CH);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N_CH-1:0] sync_in = '0;
  logic [N_CH-1:0] ch_enable = '1;
  logic [N_CH-1:0] ovf_clr = '0;
  logic            evt_ready = 1'b0;
  logic            evt_valid;
  logic [CH_W-1:0] evt_ch;
  logic            evt_level;
  logic [N_CH-1:0] overflow;
`ifdef INPUT_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] evt_time;
`endif

  input_event_arbiter #(.N_CH(N_CH), .DB_W(DB_W), .DB_CNT(DB_CNT), .TS_W(TS_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .sync_in   (sync_in),
    .ch_enable (ch_enable),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_level (evt_level),
`ifdef INPUT_EVT_TIMESTAMP_EN
    .evt_time  (evt_time),
`endif
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int lev; longint t; } exp_t;
  exp_t   q[$];
  int     hs_log[$];
  int     hs_cnt[N_CH];
  int     n_cmp = 0;
  int     n_err = 0;

  // Behavioural model: per-channel run length of "input differs from accepted level".
  int     m_stable[N_CH], m_run[N_CH], m_pend[N_CH], m_plev[N_CH], m_ovf[N_CH];
  longint m_ptime[N_CH];
  int     m_valid, m_rr;
  longint m_ts;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_stable[c] = 0; m_run[c] = 0; m_pend[c] = 0; m_plev[c] = 0; m_ovf[c] = 0; m_ptime[c] = 0;
    end
    m_valid = 0; m_rr = 0; m_ts = 0;
    q.delete();
  endtask

  task automatic model_step();
    int   win;
    bit   load, qual, granted;
    exp_t e;
    win  = -1;
    load = (m_valid == 0) || evt_ready;
    for (int k = 0; k < N_CH; k++)
      if (win < 0 && m_pend[(m_rr + k) % N_CH] != 0) win = (m_rr + k) % N_CH;
    if (load) begin
      if (win >= 0) begin
        e.ch = win; e.lev = m_plev[win]; e.t = m_ptime[win];
        q.push_back(e);
        m_valid = 1;
        m_rr = (win + 1) % N_CH;
      end else begin
        m_valid = 0;
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      granted = load && (win == c);
      if (ovf_clr[c]) m_ovf[c] = 0;
      if (!ch_enable[c]) begin
        m_stable[c] = int'(sync_in[c]); m_run[c] = 0; m_pend[c] = 0;
      end else begin
        qual = 0;
        if (int'(sync_in[c]) != m_stable[c]) begin
          m_run[c]++;
          if (m_run[c] == DB_CNT) begin
            qual = 1; m_run[c] = 0; m_stable[c] = int'(sync_in[c]);
          end
        end else begin
          m_run[c] = 0;
        end
        if (qual) begin
          if (m_pend[c] != 0 && !granted) m_ovf[c] = 1;
          m_pend[c] = 1; m_plev[c] = int'(sync_in[c]); m_ptime[c] = m_ts;
        end else if (granted) begin
          m_pend[c] = 0;
        end
      end
    end
    m_ts = (m_ts + 1) % (longint'(1) << TS_W);
  endtask

  initial forever begin
    @(posedge clk);
    if (reset) model_step();
  end

  // Monitor: compares valid/overflow every cycle and pops the scoreboard on each handshake.
  initial forever begin
    logic [N_CH-1:0] mo;
    exp_t e;
    @(negedge clk);
    if (reset) begin
      chk("evt_valid", evt_valid, m_valid);
      for (int c = 0; c < N_CH; c++) mo[c] = m_ovf[c][0];
      chk("overflow", overflow, mo);
      if (evt_valid && evt_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL handshake: got event ch %0d with no expected event at %0t", evt_ch, $time);
        end else begin
          e = q.pop_front();
          chk("evt_ch", evt_ch, e.ch);
          chk("evt_level", evt_level, e.lev);
`ifdef INPUT_EVT_TIMESTAMP_EN
          chk("evt_time", evt_time, e.t);
`endif
        end
        hs_cnt[evt_ch]++;
        hs_log.push_back(int'(evt_ch));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int lat, c1;
    for (int c = 0; c < N_CH; c++) hs_cnt[c] = 0;
    model_reset();
    #1 reset = 1'b0;
    tick(3);
    chk("reset_valid", evt_valid, 0);
    chk("reset_overflow", overflow, 0);
    reset = 1'b1;

    // Single qualified edge: latency and one-cycle pulse.
    evt_ready = 1'b1;
    tick(2);
    sync_in[2] = 1'b1;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (evt_valid) begin lat = k; break; end
    end
    chk("latency", lat, DB_CNT + 1);
    tick(1);
    chk("pulse_width", evt_valid, 0);
    tick(20);
    chk("ch2_events", hs_cnt[2], 1);

    // Glitch shorter than the debounce window.
    sync_in[0] = 1'b1; tick(5); sync_in[0] = 1'b0; tick(20);
    chk("glitch_events", hs_cnt[0], 0);
    chk("glitch_overflow", overflow, 0);

    // Bring rr_ptr back to 0, then all channels rise together.
    sync_in[2] = 1'b0; tick(20);
    sync_in[3] = 1'b1; tick(20);
    sync_in[3] = 1'b0; tick(20);
    hs_log.delete();
    sync_in = '1; tick(20);
    chk("rr_count", hs_log.size(), 4);
    for (int i = 0; i < 4 && i < hs_log.size(); i++) chk("rr_order", hs_log[i], i);

    // Stall: ch0 frozen, ch1 qualifies twice (overflow), ch3 queued.
    evt_ready = 1'b0;
    sync_in[0] = 1'b0; tick(12);
    sync_in[1] = 1'b0; tick(10);
    sync_in[1] = 1'b1; tick(10);
    sync_in[3] = 1'b0; tick(10);
    chk("stall_overflow", overflow, 4'b0010);
    chk("stall_valid", evt_valid, 1);
    chk("stall_ch", evt_ch, 0);
    hs_log.delete();
    evt_ready = 1'b1; tick(10);
    chk("stall_count", hs_log.size(), 3);
    if (hs_log.size() == 3) begin
      chk("stall_order0", hs_log[0], 0);
      chk("stall_order1", hs_log[1], 1);
      chk("stall_order2", hs_log[2], 3);
    end
    ovf_clr = 4'b0010; tick(1); ovf_clr = '0;
    chk("ovf_clr", overflow, 0);

    // Asynchronous reset in the middle of a stall.
    evt_ready = 1'b0;
    sync_in[0] = 1'b1; tick(12);
    sync_in[2] = 1'b0; tick(10);
    sync_in[2] = 1'b1; tick(10);
    chk("pre_reset_overflow", overflow, 4'b0100);
    @(negedge clk); #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_reset_valid", evt_valid, 0);
    chk("async_reset_overflow", overflow, 0);
    tick(2);
    reset = 1'b1;
    evt_ready = 1'b1;
    tick(20);

    // Disabled channel toggling produces nothing, also on re-enable.
    ch_enable[1] = 1'b0;
    c1 = hs_cnt[1];
    repeat (6) begin sync_in[1] = ~sync_in[1]; tick(12); end
    sync_in[1] = ~sync_in[1]; tick(20);
    chk("disabled_events", hs_cnt[1], c1);
    ch_enable[1] = 1'b1; tick(20);
    chk("reenable_events", hs_cnt[1], c1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 19) == 0) sync_in[c] = ~sync_in[c];
      evt_ready = ($urandom_range(0, 9) < 7);
      ovf_clr = ($urandom_range(0, 15) == 0) ? N_CH'($urandom) : '0;
      if ($urandom_range(0, 299) == 0) ch_enable[$urandom_range(0, N_CH - 1)] ^= 1'b1;
      tick(1);
    end

    ovf_clr = '0; ch_enable = '1; evt_ready = 1'b1;
    tick(40);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
